// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf-interface user-port FIFO.
// Holds the default payload width and the valid/ack transfer helper.
package leaf_pkg;

    localparam int LEAF_PAYLOAD_BITS = 32;

    // A word moves on a port only when both valid and ack are high.
    function automatic logic hs_xfer(input logic vld, input logic ack);
        return vld && ack;
    endfunction

endpackage

// File: rtl/leaf_fifo_ram.sv
// Storage array for the user-port FIFO: one synchronous write port,
// one asynchronous read port (maps to distributed/LUT RAM).
// Ports: clk, wr_en, wr_addr, wr_data (write side); rd_addr, rd_data (read side).
module leaf_fifo_ram #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [DEPTH_BITS-1:0]   wr_addr,
    input  logic [PAYLOAD_BITS-1:0] wr_data,
    input  logic [DEPTH_BITS-1:0]   rd_addr,
    output logic [PAYLOAD_BITS-1:0] rd_data
);

    logic [PAYLOAD_BITS-1:0] mem [1<<DEPTH_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/leaf_user_port_fifo.sv
// Elastic buffer between a leaf-interface output port and the HLS operator
// input it feeds; absorbs operator stalls so the leaf interface keeps draining.
// Ports: clk_user, reset (sync, active-high); din/din_vld/din_ack (leaf side);
// dout/dout_vld/dout_ack (operator side); count, almost_full (status).
// Build option LEAF_USER_PORT_FIFO_STATS_EN adds stall_cycles and xfer_count.
module leaf_user_port_fifo
    import leaf_pkg::*;
#(
    parameter int PAYLOAD_BITS       = LEAF_PAYLOAD_BITS,
    parameter int DEPTH_BITS         = 4,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                    clk_user,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    din_vld,
    output logic                    din_ack,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    dout_vld,
    input  logic                    dout_ack,
    output logic [DEPTH_BITS:0]     count,
    output logic                    almost_full
`ifdef LEAF_USER_PORT_FIFO_STATS_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             xfer_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_W  = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] MARGIN_W = (DEPTH_BITS+1)'(ALMOST_FULL_MARGIN);

    // Extra MSB is the wrap bit: it separates full from empty.
    logic [DEPTH_BITS:0]     wr_ptr;
    logic [DEPTH_BITS:0]     rd_ptr;
    logic [DEPTH_BITS:0]     used;
    logic                    empty;
    logic                    full;
    logic                    wr_en;
    logic                    rd_en;
    logic [PAYLOAD_BITS-1:0] rd_data;

    assign used  = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0])
                && (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]);

    // Status outputs come from registered state only; reset forces them
    // quiet so nothing stale or uninitialised reaches either side.
    assign din_ack     = !full && !reset;
    assign dout_vld    = !empty && !reset;
    assign dout        = dout_vld ? rd_data : '0;
    assign count       = reset ? '0 : used;
    assign almost_full = !reset && ((DEPTH_W - used) <= MARGIN_W);

    assign wr_en = hs_xfer(din_vld, din_ack);
    assign rd_en = hs_xfer(dout_vld, dout_ack);

    always_ff @(posedge clk_user) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    leaf_fifo_ram #(
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .DEPTH_BITS   (DEPTH_BITS)
    ) u_ram (
        .clk     (clk_user),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[DEPTH_BITS-1:0]),
        .wr_data (din),
        .rd_addr (rd_ptr[DEPTH_BITS-1:0]),
        .rd_data (rd_data)
    );

`ifdef LEAF_USER_PORT_FIFO_STATS_EN
    logic stall_en;

    assign stall_en = dout_vld && !dout_ack;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk_user) begin
        if (reset) begin
            stall_cycles <= '0;
            xfer_count   <= '0;
        end else begin
            if (stall_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (rd_en && (xfer_count != '1)) begin
                xfer_count <= xfer_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_leaf_user_port_fifo.sv
// Self-checking bench for leaf_user_port_fifo: queue model plus literal checks.
// Honors LEAF_USER_PORT_FIFO_STATS_EN to also check the statistics outputs.
module tb_leaf_user_port_fifo;

    logic        clk_user = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] din      = '0;
    logic        din_vld  = 1'b0;
    logic        din_ack;
    logic [31:0] dout;
    logic        dout_vld;
    logic        dout_ack = 1'b0;
    logic [4:0]  count;
    logic        almost_full;
`ifdef LEAF_USER_PORT_FIFO_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] xfer_count;
`endif

    int vectors = 0;
    int errors  = 0;

    // Behavioural model: stored words in arrival order.
    logic [31:0] q[$];
    logic [31:0] m_stall = '0;
    logic [31:0] m_xfer  = '0;

    leaf_user_port_fifo dut (
        .clk_user    (clk_user),
        .reset       (reset),
        .din         (din),
        .din_vld     (din_vld),
        .din_ack     (din_ack),
        .dout        (dout),
        .dout_vld    (dout_vld),
        .dout_ack    (dout_ack),
        .count       (count),
        .almost_full (almost_full)
`ifdef LEAF_USER_PORT_FIFO_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .xfer_count  (xfer_count)
`endif
    );

    always #5 clk_user = ~clk_user;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge, from the spec's rules.
    always @(posedge clk_user) begin
        if (reset) begin
            q.delete();
            m_stall <= '0;
            m_xfer  <= '0;
        end else begin
            automatic bit wr = din_vld && (q.size() < 16);
            automatic bit rd = dout_ack && (q.size() > 0);
            if (q.size() > 0 && !dout_ack && m_stall != 32'hFFFF_FFFF)
                m_stall <= m_stall + 1;
            if (rd && m_xfer != 32'hFFFF_FFFF)
                m_xfer <= m_xfer + 1;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(din);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk_user) begin
        automatic int n = q.size();
        if (reset) begin
            chk("rst_din_ack", {31'b0, din_ack}, 32'd0);
            chk("rst_dout_vld", {31'b0, dout_vld}, 32'd0);
            chk("rst_dout", dout, 32'd0);
            chk("rst_afull", {31'b0, almost_full}, 32'd0);
        end else begin
            chk("din_ack", {31'b0, din_ack}, {31'b0, n < 16});
            chk("dout_vld", {31'b0, dout_vld}, {31'b0, n > 0});
            chk("dout", dout, (n > 0) ? q[0] : 32'd0);
            chk("count", {27'b0, count}, 32'(n));
            chk("afull", {31'b0, almost_full}, {31'b0, (16 - n) <= 2});
`ifdef LEAF_USER_PORT_FIFO_STATS_EN
            chk("stall_cycles", stall_cycles, m_stall);
            chk("xfer_count", xfer_count, m_xfer);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk_user);
        #1;
    endtask

    task automatic drain();
        int k;
        din_vld  = 1'b0;
        dout_ack = 1'b1;
        k = 0;
        while (q.size() > 0 && k < 40) begin
            cyc();
            k++;
        end
        dout_ack = 1'b0;
        @(negedge clk_user);
        chk("drain_empty", {31'b0, dout_vld}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset, then one word
        cyc();
        cyc();
        reset = 1'b0;
        @(negedge clk_user);
        chk("t1_ack_after_rst", {31'b0, din_ack}, 32'd1);
        chk("t1_count0", {27'b0, count}, 32'd0);
        cyc();
        din = 32'hA5A5_0001;
        din_vld = 1'b1;
        cyc();
        din_vld = 1'b0;
        @(negedge clk_user);
        chk("t1_dout", dout, 32'hA5A5_0001);
        chk("t1_vld", {31'b0, dout_vld}, 32'd1);
        chk("t1_count", {27'b0, count}, 32'd1);
        drain();

        // 2: fill to full with the sink stalled; 17th word held
        cyc();
        din_vld = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            din = 32'(i);
            cyc();
            if (i == 13)
                chk("t2_afull_13", {31'b0, almost_full}, 32'd0);
            if (i == 14)
                chk("t2_afull_14", {31'b0, almost_full}, 32'd1);
        end
        @(negedge clk_user);
        chk("t2_count", {27'b0, count}, 32'd16);
        chk("t2_ack", {31'b0, din_ack}, 32'd0);
        chk("t2_afull", {31'b0, almost_full}, 32'd1);
        chk("t2_head", dout, 32'd1);

        // 3: one read from full; 17 still offered
        din = 32'd17;
        dout_ack = 1'b1;
        cyc();
        dout_ack = 1'b0;
        din_vld = 1'b0;
        @(negedge clk_user);
        chk("t3_count", {27'b0, count}, 32'd15);
        chk("t3_ack", {31'b0, din_ack}, 32'd1);
        chk("t3_head", dout, 32'd2);
        drain();

        // 4: both sides ready, 40 words
        din_vld = 1'b1;
        dout_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            din = 32'(i);
            cyc();
            chk("t4_count_le1", {31'b0, count <= 5'd1}, 32'd1);
        end
        din_vld = 1'b0;
        cyc();
        cyc();
        dout_ack = 1'b0;

        // 5: random traffic with random sink stalls
        for (int i = 0; i < 400; i++) begin
            din_vld  = ($urandom_range(0, 3) != 0);
            din      = $urandom;
            dout_ack = $urandom_range(0, 1);
            cyc();
        end
        drain();

        // 6: reset with 9 words stored
        din_vld = 1'b1;
        for (int i = 0; i < 9; i++) begin
            din = 32'h100 + 32'(i);
            cyc();
        end
        din_vld = 1'b0;
        @(negedge clk_user);
        chk("t6_count9", {27'b0, count}, 32'd9);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk_user);
        chk("t6_count0", {27'b0, count}, 32'd0);
        chk("t6_vld0", {31'b0, dout_vld}, 32'd0);
        chk("t6_dout0", dout, 32'd0);
        cyc();
        din = 32'h7;
        din_vld = 1'b1;
        cyc();
        din_vld = 1'b0;
        @(negedge clk_user);
        chk("t6_first", dout, 32'h7);
        drain();

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
